alu_share_arbiter: RTL and testbench

//   Shares one combinational ArithmeticLogicUnit between two requesters.

---
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// Each operation is granted in IDLE, executes for one cycle, then waits in RESP until it is consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [2:0]       w_sel_op;

  // Grants only exist in IDLE; on a tie the requester that did not win last time goes.
  always_comb begin
    w_state_next = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || r_last_grant)) begin
          w_grant0 = 1'b1;
        end else if (req1_valid) begin
          w_grant1 = 1'b1;
        end
        if (w_grant0 || w_grant1) begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_grant  = w_grant0 | w_grant1;
  assign w_sel_a  = w_grant1 ? req1_a  : req0_a;
  assign w_sel_b  = w_grant1 ? req1_b  : req0_b;
  assign w_sel_op = w_grant1 ? req1_op : req0_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ALU operands are only ever loaded from a grant, so they hold steady outside EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= 3'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_op     <= w_sel_op;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_valid  <= 1'b1;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_op;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level model of the arbitration rules.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_control;
  logic         alu_zero;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_ready;
  logic [W-1:0] rsp_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in ALU; op 000 is an unsigned less-than so that 7,8 -> 1 and 5,2 -> 0.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b000:  return {{(W-1){1'b0}}, (a < b)};
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return a & b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ready(rsp_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 3'd0;
    rsp_ready  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"},  {63'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_id"},     {63'd0, rsp_id}, 64'd0);
    check({tag, "_rsp_result"}, {32'd0, rsp_result}, 64'd0);
    check({tag, "_rsp_zero"},   {63'd0, rsp_zero}, 64'd0);
    check({tag, "_alu_a"},      {32'd0, alu_a}, 64'd0);
    check({tag, "_alu_b"},      {32'd0, alu_b}, 64'd0);
    check({tag, "_alu_ctl"},    {61'd0, alu_control}, 64'd0);
  endtask

  task automatic reset_dut();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  typedef struct {
    logic         v0;
    logic [W-1:0] a0, b0;
    logic [2:0]   op0;
    logic         v1;
    logic [W-1:0] a1, b1;
    logic [2:0]   op1;
    logic         rr;
    logic         e_r0, e_r1, e_rv, e_id;
    logic [W-1:0] e_res;
    logic         e_z;
  } vec_t;

  function automatic vec_t mk(input logic v0, input int a0, input int b0, input int op0,
                              input logic v1, input int a1, input int b1, input int op1,
                              input logic rr, input logic e_r0, input logic e_r1,
                              input logic e_rv, input logic e_id, input int e_res,
                              input logic e_z);
    vec_t v;
    v.v0 = v0; v.a0 = W'(a0); v.b0 = W'(b0); v.op0 = 3'(op0);
    v.v1 = v1; v.a1 = W'(a1); v.b1 = W'(b1); v.op1 = 3'(op1);
    v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv; v.e_id = e_id;
    v.e_res = W'(e_res); v.e_z = e_z;
    return v;
  endfunction

  vec_t vecs[12];

  // Random-phase model state: the outstanding operation and its age in cycles.
  logic         m_last;
  logic         m_busy;
  int           m_age;
  logic         q_id[$];
  logic [W-1:0] q_res[$];

  initial begin
    idle_inputs();

    // Both requesters always valid, consumer always ready: grants alternate 0,1,0,1.
    vecs[0]  = mk(1, 7, 8, 0,   1, 5, 2, 0,  1,  1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 7, 8, 0,   1, 5, 2, 0,  1,  0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 7, 8, 0,   1, 5, 2, 0,  1,  0, 0, 1, 0, 1, 0);
    vecs[3]  = mk(1, 7, 8, 0,   1, 5, 2, 0,  1,  0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 7, 8, 0,   1, 5, 2, 0,  1,  0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 7, 8, 0,   1, 5, 2, 0,  1,  0, 0, 1, 1, 0, 1);
    vecs[6]  = mk(1, 10, 20, 2, 1, 9, 9, 6,  1,  1, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 10, 20, 2, 1, 9, 9, 6,  1,  0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 10, 20, 2, 1, 9, 9, 6,  1,  0, 0, 1, 0, 30, 0);
    vecs[9]  = mk(1, 10, 20, 2, 1, 9, 9, 6,  1,  0, 1, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0,   0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0,   0, 0, 0, 0,  1,  0, 0, 1, 1, 0, 1);

    reset_dut();
    for (int i = 0; i < 12; i++) begin
      tick();
      req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_op = vecs[i].op0;
      req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_op = vecs[i].op1;
      rsp_ready  = vecs[i].rr;
      @(negedge clk);
      check($sformatf("vec%0d_ready0", i), {63'd0, req0_ready}, {63'd0, vecs[i].e_r0});
      check($sformatf("vec%0d_ready1", i), {63'd0, req1_ready}, {63'd0, vecs[i].e_r1});
      check($sformatf("vec%0d_rsp_valid", i), {63'd0, rsp_valid}, {63'd0, vecs[i].e_rv});
      if (vecs[i].e_rv) begin
        check($sformatf("vec%0d_rsp_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].e_id});
        check($sformatf("vec%0d_rsp_result", i), {32'd0, rsp_result}, {32'd0, vecs[i].e_res});
        check($sformatf("vec%0d_rsp_zero", i), {63'd0, rsp_zero}, {63'd0, vecs[i].e_z});
      end
    end

    // Backpressure: response held for 5 cycles, no grants until one cycle after consumption.
    reset_dut();
    tick();
    req0_valid = 1; req0_a = 10; req0_b = 3; req0_op = 3'b010;
    req1_valid = 1; req1_a = 1;  req1_b = 1; req1_op = 3'b001;
    rsp_ready  = 0;
    @(negedge clk);
    check("bp_grant0", {63'd0, req0_ready}, 64'd1);
    tick();
    @(negedge clk);
    check("bp_exec_readies", {62'd0, req0_ready, req1_ready}, 64'd0);
    check("bp_exec_alu_a", {32'd0, alu_a}, 64'd10);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", k), {63'd0, rsp_valid}, 64'd1);
      check($sformatf("bp_hold%0d_result", k), {32'd0, rsp_result}, 64'd13);
      check($sformatf("bp_hold%0d_id", k), {63'd0, rsp_id}, 64'd0);
      check($sformatf("bp_hold%0d_readies", k), {62'd0, req0_ready, req1_ready}, 64'd0);
    end
    tick();
    rsp_ready = 1;
    @(negedge clk);
    check("bp_accept_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_accept_readies", {62'd0, req0_ready, req1_ready}, 64'd0);
    tick();
    @(negedge clk);
    check("bp_after_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_after_grant1", {62'd0, req0_ready, req1_ready}, 64'd1);

    // Reset pulse while EXEC is in flight: nothing comes out, req0 wins the next tie.
    reset_dut();
    tick();
    req0_valid = 1; req0_a = 7; req0_b = 8; req0_op = 3'b000;
    rsp_ready  = 1;
    @(negedge clk);
    check("rst_grant0", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("rst_exec_alu_a", {32'd0, alu_a}, 64'd7);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("rst_quiet%0d", k), {63'd0, rsp_valid}, 64'd0);
    end
    tick();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("rst_next_grant", {62'd0, req0_ready, req1_ready}, 64'd2);

    // req1 pulses valid only while the arbiter is busy: it must never be served.
    reset_dut();
    tick();
    req0_valid = 1; req0_a = 5; req0_b = 2; req0_op = 3'b000;
    rsp_ready  = 1;
    @(negedge clk);
    check("drop_grant0", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 3'b010;
    @(negedge clk);
    check("drop_busy_ready1", {63'd0, req1_ready}, 64'd0);
    tick();
    req1_valid = 0;
    @(negedge clk);
    check("drop_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("drop_rsp_id", {63'd0, rsp_id}, 64'd0);
    check("drop_rsp_result", {32'd0, rsp_result}, 64'd0);
    check("drop_rsp_zero", {63'd0, rsp_zero}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("drop_quiet%0d", k), {62'd0, rsp_valid, req1_ready}, 64'd0);
    end

    // Random traffic against a transaction-level model.
    reset_dut();
    m_last = 1'b1;
    m_busy = 1'b0;
    m_age  = 0;
    for (int c = 0; c < 3000; c++) begin
      logic e_r0, e_r1, e_rv, winner;
      tick();
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);

      e_r0 = 1'b0; e_r1 = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) winner = ~m_last;
        else                          winner = req1_valid;
        e_r0 = (winner == 1'b0);
        e_r1 = (winner == 1'b1);
      end
      e_rv = m_busy && (m_age >= 1);

      check($sformatf("rnd%0d_readies", c), {62'd0, req0_ready, req1_ready}, {62'd0, e_r0, e_r1});
      check($sformatf("rnd%0d_rsp_valid", c), {63'd0, rsp_valid}, {63'd0, e_rv});
      if (e_rv && q_id.size() > 0) begin
        check($sformatf("rnd%0d_rsp_id", c), {63'd0, rsp_id}, {63'd0, q_id[0]});
        check($sformatf("rnd%0d_rsp_result", c), {32'd0, rsp_result}, {32'd0, q_res[0]});
        check($sformatf("rnd%0d_rsp_zero", c), {63'd0, rsp_zero}, {63'd0, (q_res[0] == '0)});
      end

      if (m_busy) begin
        if (e_rv && rsp_ready) begin
          m_busy = 1'b0;
          void'(q_id.pop_front());
          void'(q_res.pop_front());
        end else begin
          m_age++;
        end
      end else if (e_r0 || e_r1) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_last = e_r1;
        q_id.push_back(e_r1);
        q_res.push_back(e_r1 ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
